// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_prefetch_queue                                                       |
// | Fetch PC owner, in-order imem requester and PC-tagged prefetch FIFO feeding|
// | decode; EX redirects flush the queue and drop stale responses.             |
// | Optional: PREFETCH_BYPASS_EN forwards a response to decode when the queue  |
// | is empty.                                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_accept;
  logic          bypass;
  logic          deq_fire;
  logic          do_enq;
  logic          do_deq;

  // Every outstanding request owns a FIFO slot, so a response can never overflow.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = ~reset & ~redirect & (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_accept     = imem_rsp_valid & ~redirect & (drop == '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_accept & (count == '0) & ~reset;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid   = ~redirect & ((count != '0) | bypass);
  assign instr         = bypass ? imem_rsp_data : fifo_instr[rd_ptr];
  assign instr_pc      = bypass ? rsp_pc : fifo_pc[rd_ptr];
  assign instr_pcplus4 = instr_pc + 32'd4;

  assign deq_fire = instr_valid & instr_ready;
  // A bypassed word consumed by decode never lands in the FIFO.
  assign do_enq   = rsp_accept & ~(bypass & deq_fire);
  assign do_deq   = deq_fire & ~bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rsp_pc   <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Everything still outstanding after this cycle belongs to the old path.
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_rsp_valid) begin
          if (drop != '0) begin
            drop <= drop - CW'(1);
          end else begin
            rsp_pc <= rsp_pc + 32'd4;
          end
        end
        if (do_enq) begin
          fifo_instr[wr_ptr] <= imem_rsp_data;
          fifo_pc[wr_ptr]    <= rsp_pc;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (do_deq) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(do_enq) - CW'(do_deq);
      end
    end
  end

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (inflight == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// Bench for fetch_prefetch_queue: queue-level reference model plus an
// in-order fixed-latency instruction memory, with directed scenarios.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pcplus4 (instr_pcplus4),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } pend_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int n_req = 0;
  int first_valid_cyc = -1;

  mreq_t       mem_q[$];
  pend_t       m_pend[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] deq_log[$];
  logic [31:0] deq_p4_log[$];

  logic        s_reset = 1'b1;
  logic        s_ready = 1'b1;
  logic        s_req_ready = 1'b1;
  logic        s_redirect = 1'b0;
  logic [31:0] s_redirect_pc = 32'h0;

  logic        smp_req_valid;
  logic        smp_ivalid;
  logic [31:0] smp_addr;
  logic [31:0] smp_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < deq_log.size()) return deq_log[i];
    return 32'hBAD0_BAD0;
  endfunction

  // One clock: drive inputs at negedge, compare against the model, advance it.
  task automatic cycle();
    bit    exp_rv;
    bit    exp_iv;
    bit    rsp;
    pend_t p;
    mreq_t m;
    @(negedge clk);
    reset          = s_reset;
    instr_ready    = s_ready;
    imem_req_ready = s_req_ready;
    redirect       = s_redirect;
    redirect_pc    = s_redirect_pc;
    if (s_reset) begin
      mem_q.delete();
      m_pend.delete();
      m_fifo.delete();
      m_fetch_pc = RESET_PC;
      cyc = 0;
    end else begin
      cyc++;
    end
    rsp = !s_reset && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    if (rsp) imem_rsp_data = word_of(mem_q[0].addr);
    else     imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    smp_req_valid = imem_req_valid;
    smp_ivalid    = instr_valid;
    smp_addr      = imem_req_addr;
    smp_pc        = instr_pc;
    if (s_reset) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_pcplus4", instr_pcplus4, 32'd4);
    end else begin
      exp_rv = !s_redirect && ((m_fifo.size() + m_pend.size()) < DEPTH);
      exp_iv = !s_redirect && (m_fifo.size() != 0);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
      if (exp_iv) begin
        chk("instr_pc", instr_pc, m_fifo[0]);
        chk("instr", instr, word_of(m_fifo[0]));
        chk("instr_pcplus4", instr_pcplus4, m_fifo[0] + 32'd4);
      end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready) begin
        deq_log.push_back(instr_pc);
        deq_p4_log.push_back(instr_pcplus4);
      end
      // Memory reacts to what the DUT really issues.
      if (rsp) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        mem_q.push_back(m);
        n_req++;
      end
      if (s_redirect) begin
        m_fifo.delete();
        if (rsp && m_pend.size() > 0) void'(m_pend.pop_front());
        foreach (m_pend[i]) m_pend[i].stale = 1'b1;
        m_fetch_pc = {s_redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_iv && s_ready) void'(m_fifo.pop_front());
        if (rsp && m_pend.size() > 0) begin
          p = m_pend.pop_front();
          if (!p.stale) m_fifo.push_back(p.pc);
        end
        if (exp_rv && s_req_ready) begin
          p.pc    = m_fetch_pc;
          p.stale = 1'b0;
          m_pend.push_back(p);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int l);
    s_reset     = 1'b1;
    s_redirect  = 1'b0;
    s_ready     = 1'b1;
    s_req_ready = 1'b1;
    lat         = l;
    run(2);
    s_reset         = 1'b0;
    n_req           = 0;
    first_valid_cyc = -1;
    deq_log.delete();
    deq_p4_log.delete();
  endtask

  initial begin
    // Streaming, L=1.
    do_reset(1);
    run(1);
    chk("t1_first_req_valid", {31'b0, smp_req_valid}, 32'd1);
    chk("t1_first_req_addr", smp_addr, 32'h0);
    run(2);
    chk("t1_c3_valid", {31'b0, smp_ivalid}, 32'd1);
    chk("t1_c3_pc", smp_pc, 32'h0);
    run(6);
    chk("t1_deq_count", 32'(deq_log.size()), 32'd7);
    chk("t1_deq_last", log_at(6), 32'h18);

    // Decode stalled for 10 cycles, then released.
    do_reset(1);
    s_ready = 1'b0;
    run(10);
    chk("t2_req_count", 32'(n_req), 32'd4);
    chk("t2_req_valid_off", {31'b0, smp_req_valid}, 32'd0);
    chk("t2_head_held", smp_pc, 32'h0);
    s_ready = 1'b1;
    run(8);
    for (int i = 0; i < 4; i++) chk("t2_order", log_at(i), 32'(4 * i));

    // Redirect with three requests outstanding, L=4.
    do_reset(4);
    run(3);
    s_redirect    = 1'b1;
    s_redirect_pc = 32'h100;
    run(1);
    chk("t3_redir_req_valid", {31'b0, smp_req_valid}, 32'd0);
    s_redirect = 1'b0;
    run(8);
    chk("t3_first_valid_cyc", 32'(first_valid_cyc), 32'd10);
    chk("t3_first_pc", log_at(0), 32'h100);

    // Redirect coinciding with a response and an attempted dequeue, L=2.
    do_reset(2);
    run(3);
    s_redirect    = 1'b1;
    s_redirect_pc = 32'h200;
    run(1);
    chk("t4_redir_ivalid", {31'b0, smp_ivalid}, 32'd0);
    s_redirect = 1'b0;
    run(6);
    chk("t4_first_valid_cyc", 32'(first_valid_cyc), 32'd8);
    chk("t4_first_pc", log_at(0), 32'h200);

    // Fetch PC wrap at the top of the address space (low bits ignored).
    do_reset(1);
    s_redirect    = 1'b1;
    s_redirect_pc = 32'hFFFF_FFFE;
    run(1);
    s_redirect = 1'b0;
    run(6);
    chk("t5_pc_top", log_at(0), 32'hFFFF_FFFC);
    chk("t5_pc_wrap", log_at(1), 32'h0);
    chk("t5_pcplus4_wrap", (deq_p4_log.size() > 0) ? deq_p4_log[0] : 32'hBAD0_BAD0, 32'h0);

    // Reset mid-flight: two queued, two outstanding.
    do_reset(3);
    s_ready = 1'b0;
    run(5);
    s_reset = 1'b1;
    run(1);
    chk("t6_reset_ivalid", {31'b0, smp_ivalid}, 32'd0);
    chk("t6_reset_req_valid", {31'b0, smp_req_valid}, 32'd0);
    do_reset(1);
    run(1);
    chk("t6_restart_valid", {31'b0, smp_req_valid}, 32'd1);
    chk("t6_restart_addr", smp_addr, RESET_PC);
    run(4);
    chk("t6_restart_pc", log_at(0), RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
